// File: rtl/data_memory_ctrl.sv
// Single-port data memory behind a valid/ready request/response handshake.
// Byte-lane writes, configurable response latency, error responses for bad addresses.
module data_memory_ctrl #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DEPTH    = 256,
    parameter int unsigned READ_LAT = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic                resp_err
);

    localparam int unsigned BYTES = DATA_W / 8;
    localparam int unsigned OFFS  = $clog2(BYTES);
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state;
    logic               idle_q;
    logic [CNT_W-1:0]   cnt;
    logic [DATA_W-1:0]  data_q;
    logic               err_q;
    logic [DATA_W-1:0]  mem [DEPTH];

    logic [IDX_W-1:0]   idx;
    logic               misaligned;
    logic               out_of_range;
    logic               acc_err;
    logic               accept;
    logic [DATA_W-1:0]  rd_word;

    // Address decode; upper bits above the word index alias nothing, they are an error
    assign idx          = req_addr[OFFS +: IDX_W];
    assign misaligned   = (req_addr & ADDR_W'(BYTES - 1)) != '0;
    assign out_of_range = (req_addr >> (OFFS + IDX_W)) != '0;
    assign acc_err      = misaligned | out_of_range;

    // A request presented while rst is high is never accepted
    assign req_ready = idle_q & ~rst;
    assign accept    = req_valid & req_ready;
    assign rd_word   = (req_we | acc_err) ? '0 : mem[idx];

    // Storage: writes commit at the accept edge, lane by lane
    always_ff @(posedge clk) begin
        if (accept && req_we && !acc_err) begin
            for (int i = 0; i < int'(BYTES); i++) begin
                if (req_be[i]) begin
                    mem[idx][8*i +: 8] <= req_wdata[8*i +: 8];
                end
            end
        end
    end

    // Transaction FSM with registered response outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            idle_q     <= 1'b1;
            cnt        <= '0;
            data_q     <= '0;
            err_q      <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        idle_q <= 1'b0;
                        data_q <= rd_word;
                        err_q  <= acc_err;
                        if (READ_LAT <= 1) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_rdata <= rd_word;
                            resp_err   <= acc_err;
                        end else begin
                            state <= WAIT;
                            cnt   <= CNT_W'(READ_LAT - 1);
                        end
                    end
                end
                WAIT: begin
                    // Counter reaching zero on this edge puts resp_valid up READ_LAT edges after accept
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_rdata <= data_q;
                        resp_err   <= err_q;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        idle_q     <= 1'b1;
                        resp_valid <= 1'b0;
                        resp_rdata <= '0;
                        resp_err   <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    idle_q <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Scoreboard bench for data_memory_ctrl: one instance at READ_LAT=1, one at READ_LAT=3,
// sharing clock, reset and request payload, each with its own req_valid.
module tb_data_memory_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid1 = 1'b0;
    logic        valid3 = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  be = '0;
    logic        resp_ready = 1'b0;

    logic        ready1, ready3, rv1, rv3, err1, err3;
    logic [31:0] rd1, rd3;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model1 [256];
    logic [31:0] model3 [256];
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    data_memory_ctrl #(.DATA_W(32), .ADDR_W(32), .DEPTH(256), .READ_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .req_valid(valid1), .req_ready(ready1), .req_we(we),
        .req_addr(addr), .req_wdata(wdata), .req_be(be), .resp_valid(rv1),
        .resp_ready(resp_ready), .resp_rdata(rd1), .resp_err(err1)
    );

    data_memory_ctrl #(.DATA_W(32), .ADDR_W(32), .DEPTH(256), .READ_LAT(3)) dut3 (
        .clk(clk), .rst(rst), .req_valid(valid3), .req_ready(ready3), .req_we(we),
        .req_addr(addr), .req_wdata(wdata), .req_be(be), .resp_valid(rv3),
        .resp_ready(resp_ready), .resp_rdata(rd3), .resp_err(err3)
    );

    function automatic logic f_ready(input int s);
        return (s == 3) ? ready3 : ready1;
    endfunction

    function automatic logic f_rv(input int s);
        return (s == 3) ? rv3 : rv1;
    endfunction

    function automatic logic f_err(input int s);
        return (s == 3) ? err3 : err1;
    endfunction

    function automatic logic [31:0] f_rd(input int s);
        return (s == 3) ? rd3 : rd1;
    endfunction

    // Model of one access: expected response, and the memory update for good writes
    task automatic model_access(input int s, input logic w, input logic [31:0] a,
                                input logic [31:0] d, input logic [3:0] b, output exp_t e);
        logic       bad;
        logic [7:0] ix;
        logic [31:0] word;
        bad  = (a[1:0] != 2'b00) || (a[31:10] != 22'd0);
        ix   = a[9:2];
        word = (s == 3) ? model3[ix] : model1[ix];
        e.err   = bad;
        e.rdata = (w || bad) ? 32'd0 : word;
        if (w && !bad) begin
            for (int i = 0; i < 4; i++) begin
                if (b[i]) word[8*i +: 8] = d[8*i +: 8];
            end
            if (s == 3) model3[ix] = word;
            else        model1[ix] = word;
        end
    endtask

    // Issue one request on dut s, check latency, payload, hold stability and return to idle
    task automatic transact(input int s, input logic w, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] b, input int hold,
                            input string name);
        int   t;
        exp_t e;
        t = 0;
        while (!f_ready(s) && t < 50) begin
            @(negedge clk);
            t++;
        end
        n_cmp++;
        if (t >= 50) begin
            n_bad++;
            $display("FAIL %s: req_ready never rose (got 0, need 1)", name);
            return;
        end
        model_access(s, w, a, d, b, e);
        sb.push_back(e);
        we = w; addr = a; wdata = d; be = b;
        if (s == 3) valid3 = 1'b1;
        else        valid1 = 1'b1;
        @(negedge clk);
        valid1 = 1'b0; valid3 = 1'b0;
        we = 1'($urandom); addr = $urandom; wdata = $urandom; be = 4'($urandom);
        t = 1;
        while (!f_rv(s) && t < 50) begin
            @(negedge clk);
            t++;
        end
        e = sb.pop_front();
        n_cmp++;
        if (t != s) begin
            n_bad++;
            $display("FAIL %s latency: got %0d cycles, need %0d", name, t, s);
            if (t >= 50) return;
        end
        n_cmp++;
        if (f_rd(s) !== e.rdata || f_err(s) !== e.err || f_ready(s) !== 1'b0) begin
            n_bad++;
            $display("FAIL %s resp: got rdata=%h err=%b ready=%b, need rdata=%h err=%b ready=0",
                     name, f_rd(s), f_err(s), f_ready(s), e.rdata, e.err);
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            n_cmp++;
            if (f_rv(s) !== 1'b1 || f_rd(s) !== e.rdata || f_err(s) !== e.err || f_ready(s) !== 1'b0) begin
                n_bad++;
                $display("FAIL %s hold%0d: got valid=%b rdata=%h err=%b ready=%b, need 1/%h/%b/0",
                         name, i, f_rv(s), f_rd(s), f_err(s), f_ready(s), e.rdata, e.err);
            end
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        n_cmp++;
        if (f_rv(s) !== 1'b0 || f_ready(s) !== 1'b1) begin
            n_bad++;
            $display("FAIL %s release: got valid=%b ready=%b, need valid=0 ready=1",
                     name, f_rv(s), f_ready(s));
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (rv1 !== 1'b0 || rv3 !== 1'b0 || rd1 !== 32'd0 || rd3 !== 32'd0 ||
            err1 !== 1'b0 || err3 !== 1'b0 || ready1 !== 1'b0 || ready3 !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_state: got rv=%b%b rd=%h/%h err=%b%b ready=%b%b, need all 0",
                     rv1, rv3, rd1, rd3, err1, err3, ready1, ready3);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (ready1 !== 1'b1 || ready3 !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_release: got ready=%b%b, need 11", ready1, ready3);
        end
        @(negedge clk);
    endtask

    task automatic test_basic_rw();
        transact(1, 1'b1, 32'h4, 32'h0000_0001, 4'hF, 0, "wr4");
        transact(1, 1'b0, 32'h4, 32'h0, 4'h0, 0, "rd4");
    endtask

    task automatic test_byte_lanes();
        transact(1, 1'b1, 32'h8, 32'hAABB_CCDD, 4'hF, 0, "wr8_full");
        transact(1, 1'b1, 32'h8, 32'h1122_3344, 4'b0101, 0, "wr8_lanes");
        transact(1, 1'b0, 32'h8, 32'h0, 4'h0, 0, "rd8_merged");
        transact(1, 1'b1, 32'h8, 32'hFFFF_FFFF, 4'h0, 0, "wr8_be0");
        transact(1, 1'b0, 32'h8, 32'h0, 4'h0, 0, "rd8_after_be0");
    endtask

    task automatic test_errors();
        transact(1, 1'b1, 32'h0, 32'h0BAD_F00D, 4'hF, 0, "wr0");
        transact(1, 1'b0, 32'h6, 32'h0, 4'h0, 0, "rd_misaligned");
        transact(1, 1'b0, 32'h400, 32'h0, 4'h0, 0, "rd_out_of_range");
        // 0x400 shares index bits with word 0; an erroring write must not land there
        transact(1, 1'b1, 32'h400, 32'h1234_5678, 4'hF, 0, "wr_out_of_range");
        transact(1, 1'b1, 32'h1, 32'h1234_5678, 4'hF, 0, "wr_misaligned");
        transact(1, 1'b0, 32'h0, 32'h0, 4'h0, 0, "rd0_unchanged");
    endtask

    task automatic test_backpressure();
        transact(1, 1'b0, 32'h4, 32'h0, 4'h0, 5, "rd4_hold5");
    endtask

    task automatic test_latency3();
        transact(3, 1'b1, 32'h10, 32'h0000_0012, 4'hF, 0, "l3_wr10");
        transact(3, 1'b0, 32'h10, 32'h0, 4'h0, 0, "l3_rd10");
        transact(3, 1'b0, 32'h6, 32'h0, 4'h0, 1, "l3_rd_misaligned");
    endtask

    task automatic test_back_to_back();
        for (int w = 0; w < 8; w++) begin
            transact(3, 1'b1, 32'(w * 4), $urandom, 4'hF, 0, "b2b_init3");
            transact(1, 1'b1, 32'(w * 4), $urandom, 4'hF, 0, "b2b_init1");
        end
        for (int k = 0; k < 24; k++) begin
            logic [31:0] a;
            int          s;
            s = (k % 2 == 0) ? 3 : 1;
            a = 32'($urandom_range(0, 7) * 4);
            if (k % 7 == 3) a = a | 32'h2;
            if (k % 9 == 5) a = a | 32'h800;
            transact(s, 1'($urandom), a, $urandom, 4'($urandom), int'($urandom_range(0, 2)), "b2b");
        end
    endtask

    task automatic test_reset_mid();
        transact(3, 1'b1, 32'h14, 32'h5555_5555, 4'hF, 0, "rm_wr14");
        while (!ready3) @(negedge clk);
        model3[8'h03] = 32'hC0FF_EE00;
        we = 1'b1; addr = 32'hC; wdata = 32'hC0FF_EE00; be = 4'hF; valid3 = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        // Request held during reset must be ignored
        we = 1'b1; addr = 32'h14; wdata = 32'hDEAD_BEEF; be = 4'hF; valid3 = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_cmp++;
            if (rv3 !== 1'b0 || ready3 !== 1'b0) begin
                n_bad++;
                $display("FAIL rm_in_reset: got valid=%b ready=%b, need 0/0", rv3, ready3);
            end
        end
        rst = 1'b0;
        valid3 = 1'b0;
        #1;
        n_cmp++;
        if (ready3 !== 1'b1 || rv3 !== 1'b0) begin
            n_bad++;
            $display("FAIL rm_release: got ready=%b valid=%b, need 1/0", ready3, rv3);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++;
            if (rv3 !== 1'b0) begin
                n_bad++;
                $display("FAIL rm_no_resp: got valid=%b, need 0", rv3);
            end
        end
        transact(3, 1'b0, 32'hC, 32'h0, 4'h0, 0, "rm_rdC");
        transact(3, 1'b0, 32'h14, 32'h0, 4'h0, 0, "rm_rd14");
    endtask

    initial begin
        test_reset();
        test_basic_rw();
        test_byte_lanes();
        test_errors();
        test_backpressure();
        test_latency3();
        test_back_to_back();
        test_reset_mid();
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d left, need 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
